rank_logic_cell: RTL and testbench

Per-cell rank update element of the rank-order filter's sorted-window array. Each instance compares the incoming sample with its stored sample and computes the cell's next rank after the oldest sample (rank `r_0`) is evicted and the new sample is inserted. It also reports whether the new sample ranks at or above the stored one. The array sums that flag across cells to obtain the new sample's own rank.

---
 rtl/rank_logic_cell_if.sv | 42 ++++
 rtl/rank_logic_cell.sv | 74 +++++++
 tb/tb_rank_logic_cell.sv | 110 +++++++++++
 3 files changed

// File: rtl/rank_logic_cell_if.sv
// ============================================================================
// Module      : rank_logic_cell_if
// Description : Sample/rank bundle between the sorted-window array and one
//               rank_logic_cell. Optional macro: RANK_LOGIC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rank_logic_cell_if #(
  parameter int data_bits = 8,
  parameter int rank_bits = 2
);
  logic                 i_valid;
  logic [data_bits-1:0] i_new;
  logic [data_bits-1:0] s_n;
  logic [rank_bits-1:0] r_n;
  logic [rank_bits-1:0] r_0;
  logic [rank_bits-1:0] new_r;
  logic                 i_is_ge;
  logic                 o_valid;
`ifdef RANK_LOGIC_CHECK_EN
  logic                 o_rank_err;
`endif

  modport master (
    output i_valid, i_new, s_n, r_n, r_0,
`ifdef RANK_LOGIC_CHECK_EN
    input  o_rank_err,
`endif
    input  new_r, i_is_ge, o_valid
  );

  modport slave (
    input  i_valid, i_new, s_n, r_n, r_0,
`ifdef RANK_LOGIC_CHECK_EN
    output o_rank_err,
`endif
    output new_r, i_is_ge, o_valid
  );
endinterface

`default_nettype wire

// File: rtl/rank_logic_cell.sv
// ============================================================================
// Module      : rank_logic_cell
// Description : Per-cell rank update for the rank-order filter window; one
//               registered result per valid input. Optional macro:
//               RANK_LOGIC_CHECK_EN adds the o_rank_err wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rank_logic_cell #(
  parameter int data_bits = 8,
  parameter int rank_bits = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  rank_logic_cell_if.slave bus
);

  logic                 w_ge;
  logic                 w_dec;
  logic                 w_inc;
  logic [rank_bits-1:0] w_next_r;

  logic [rank_bits-1:0] r_new_r;
  logic                 r_is_ge;
  logic                 r_valid;

  // Ties count as ge, so an equal new sample never bumps the stored rank.
  always_comb begin
    w_ge     = (bus.i_new >= bus.s_n);
    w_dec    = (bus.r_n > bus.r_0);
    w_inc    = ~w_ge;
    w_next_r = bus.r_n - rank_bits'(w_dec) + rank_bits'(w_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_r <= '0;
      r_is_ge <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_new_r <= w_next_r;
        r_is_ge <= w_ge;
      end
    end
  end

  assign bus.new_r   = r_new_r;
  assign bus.i_is_ge = r_is_ge;
  assign bus.o_valid = r_valid;

`ifdef RANK_LOGIC_CHECK_EN
  logic w_wrap;
  logic r_rank_err;

  // Only a lone increment from the top rank can wrap; dec cancels it.
  assign w_wrap = w_inc & ~w_dec & (bus.r_n == {rank_bits{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rank_err <= 1'b0;
    end else if (bus.i_valid) begin
      r_rank_err <= w_wrap;
    end
  end

  assign bus.o_rank_err = r_rank_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rank_logic_cell.sv
// ============================================================================
// Module      : tb_rank_logic_cell
// Description : Directed plus randomized check of rank_logic_cell against an
//               integer reference model. Honours RANK_LOGIC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rank_logic_cell;
  localparam int DB = 8;
  localparam int RB = 2;
  localparam int NR = 1 << RB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rank_logic_cell_if #(.data_bits(DB), .rank_bits(RB)) bus ();

  rank_logic_cell #(.data_bits(DB), .rank_bits(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the outputs should show after the last edge.
  int m_r   = 0;
  int m_ge  = 0;
  int m_v   = 0;
  int m_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input int nw, input int s,
                      input int rn, input int r0);
    int rank_after;
    @(negedge clk);
    rst         = r;
    bus.i_valid = v;
    bus.i_new   = nw[DB-1:0];
    bus.s_n     = s[DB-1:0];
    bus.r_n     = rn[RB-1:0];
    bus.r_0     = r0[RB-1:0];
    if (r) begin
      m_r = 0; m_ge = 0; m_v = 0; m_err = 0;
    end else begin
      m_v = v;
      if (v) begin
        // Evicting a lower-ranked sample moves us down; a smaller newcomer moves us up.
        rank_after = rn;
        if (rn > r0) rank_after = rank_after - 1;
        if (nw < s)  rank_after = rank_after + 1;
        m_err = (rank_after >= NR) ? 1 : 0;
        m_r   = ((rank_after % NR) + NR) % NR;
        m_ge  = (nw >= s) ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    check("o_valid", 32'(bus.o_valid), 32'(m_v));
    check("new_r",   32'(bus.new_r),   32'(m_r));
    check("i_is_ge", 32'(bus.i_is_ge), 32'(m_ge));
`ifdef RANK_LOGIC_CHECK_EN
    check("o_rank_err", 32'(bus.o_rank_err), 32'(m_err));
`endif
  endtask

  initial begin
    bus.i_valid = 1'b1;
    bus.i_new   = '0;
    bus.s_n     = '0;
    bus.r_n     = '0;
    bus.r_0     = '0;

    step(1, 1, 7, 3, 2, 0);            // reset beats a valid input
    step(0, 1, 0, 0, 1, 2);            // tie, below evicted rank
    step(0, 1, 3, 0, 1, 0);            // decrement
    step(0, 1, 0, 5, 1, 2);            // increment
    step(0, 1, 1, 9, 3, 0);            // cancel
    step(0, 0, 200, 1, 0, 3);          // hold
    step(0, 1, 0, 1, 3, 3);            // wrap
    step(0, 1, 255, 255, 0, 0);        // full-width tie
    step(0, 1, 0, 255, 2, 1);          // extremes, cancel
    step(1, 1, 0, 1, 3, 3);            // reset discards in-flight result
    step(0, 0, 0, 1, 3, 3);            // no fresh valid -> stays cleared

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, NR - 1)),
           int'($urandom_range(0, NR - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
